// File: rtl/fetch_unit.sv
// Fetch stage: issues word-aligned imem requests, buffers in-order {pc, instr} responses for decode.
// Response -> o_valid one cycle later; request issue is credit-limited so the queue never overflows under decode stall.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ready,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [31:0]     o_instr,
  input  logic            i_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            run_q;
  logic [XLEN-1:0] pc_mem_q  [DEPTH];
  logic [31:0]     ins_mem_q [DEPTH];

  logic [XLEN-1:0] tgt_pc;
  logic [CW:0]     used;
  logic            fire, rsp_acc, push, pop;

  assign tgt_pc  = i_redirect_pc & ~(XLEN'(3));
  // Credits cover both buffered entries and responses still in flight.
  assign used    = {1'b0, count_q} + {1'b0, outst_q};
  assign o_imem_req  = run_q & ~i_redirect & (used < (CW+1)'(DEPTH));
  assign o_imem_addr = fetch_pc_q;
  assign fire    = o_imem_req & i_imem_ready;
  assign rsp_acc = i_imem_rvalid & (outst_q != '0);
  assign push    = rsp_acc & (drop_q == '0) & ~i_redirect;

  assign o_valid    = (count_q != '0) & ~i_redirect;
  assign pop        = o_valid & i_ready;
  assign o_pc       = pc_mem_q[rd_ptr_q];
  assign o_pc_plus4 = o_pc + XLEN'(4);
  assign o_instr    = ins_mem_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (i_redirect) begin
      fetch_pc_d = tgt_pc;
      resp_pc_d  = tgt_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      outst_d    = outst_q - CW'(rsp_acc);
      // Everything still in flight belongs to the old stream, including already-dropped ones.
      drop_d     = outst_q - CW'(rsp_acc);
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      outst_d = outst_q + CW'(fire) - CW'(rsp_acc);
      if (rsp_acc && drop_q != '0) drop_d = drop_q - CW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
        wr_ptr_d  = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      run_q      <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]  <= resp_pc_q;
      ins_mem_q[wr_ptr_q] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus an expected-stream reference (fetch and decode PC sequences).
module tb_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready = 1'b1;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_valid;
  logic [31:0] o_pc, o_pc_plus4, o_instr;
  logic        i_ready = 1'b1;

  always #5 i_clk = ~i_clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_ready(i_imem_ready),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata), .o_valid(o_valid),
    .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_instr(o_instr), .i_ready(i_ready)
  );

  int errors = 0, checks = 0;
  int cyc = 0, s_cyc = 0, last_due = 0;
  int lat_min = 1, lat_max = 1;
  int n_pop = 0, n_fire = 0;
  bit spurious_en = 1'b0, saw_wrap = 1'b0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_fetch = '0, exp_dec = '0;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;

  typedef struct {
    logic [31:0] target;
    int          lat;
    logic [31:0] exp_addr;
    logic [31:0] exp_addr2;
  } redir_vec_t;
  redir_vec_t vecs[5];

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: called just after a falling edge with control inputs already set.
  task automatic tick();
    bit rv, spur, fire, pop;
    int d;
    rv   = (pend_addr.size() != 0) && (pend_due[0] <= cyc);
    spur = !rv && spurious_en && (pend_addr.size() == 0) && ($urandom_range(0, 9) == 0);
    i_imem_rvalid = rv | spur;
    i_imem_rdata  = rv ? hash(pend_addr[0]) : $urandom();
    #1;
    s_cyc = cyc; s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_valid; s_pc = o_pc;
    fire = s_req & i_imem_ready;
    pop  = s_valid & i_ready;
    if (i_redirect) begin
      check("redirect_req_low", {31'b0, s_req}, 32'd0);
      check("redirect_valid_low", {31'b0, s_valid}, 32'd0);
    end
    if (s_req) check("fetch_addr", s_addr, exp_fetch);
    if (s_valid) begin
      check("head_pc", s_pc, exp_dec);
      check("head_instr", o_instr, hash(exp_dec));
      check("head_pc_plus4", o_pc_plus4, exp_dec + 32'd4);
    end
    if (rv) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (i_redirect) begin
      exp_fetch = i_redirect_pc & 32'hFFFFFFFC;
      exp_dec   = exp_fetch;
    end else begin
      if (fire) begin
        d = cyc + int'($urandom_range(lat_min, lat_max));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        pend_addr.push_back(s_addr);
        pend_due.push_back(d);
        exp_fetch = exp_fetch + 32'd4;
        n_fire++;
      end
      if (pop) begin
        if (exp_dec == 32'hFFFFFFFC) saw_wrap = 1'b1;
        exp_dec = exp_dec + 32'd4;
        n_pop++;
      end
    end
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic wait_req(input string name, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      ok = s_req;
    end
    check({name, "_timeout"}, {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_valid(input string name, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      ok = s_valid;
    end
    check({name, "_timeout"}, {31'b0, ok}, 32'd1);
  endtask

  // Asynchronous reset asserted between edges, then released with the 1-cycle request latency checked.
  task automatic async_reset();
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_imem_req", {31'b0, o_imem_req}, 32'd0);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_pc", o_pc, 32'd0);
    check("rst_instr", o_instr, 32'd0);
    pend_addr.delete();
    pend_due.delete();
    i_imem_rvalid = 1'b0;
    i_redirect = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_fetch = 32'h0;
    exp_dec = 32'h0;
    last_due = cyc;
    n_fire = 0;
    tick();
    check("release_req_cycle0", {31'b0, s_req}, 32'd0);
    tick();
    check("release_req_cycle1", {31'b0, s_req}, 32'd1);
  endtask

  initial begin
    int fcyc, n0;
    vecs[0] = '{32'h00000100, 3, 32'h00000100, 32'h00000104};
    vecs[1] = '{32'hFFFFFFFE, 1, 32'hFFFFFFFC, 32'h00000000};
    vecs[2] = '{32'h00000203, 2, 32'h00000200, 32'h00000204};
    vecs[3] = '{32'h00000007, 1, 32'h00000004, 32'h00000008};
    vecs[4] = '{32'h80000041, 4, 32'h80000040, 32'h80000044};

    // Back-to-back streaming with 1-cycle memory.
    async_reset();
    fcyc = s_cyc;
    wait_valid("first_valid", 10);
    check("fill_latency", s_cyc - fcyc, 32'd2);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stream_no_gap", {31'b0, s_valid}, 32'd1);
    end

    // Decode stall from reset: exactly DEPTH requests, head holds 0x0.
    i_ready = 1'b0;
    async_reset();
    repeat (8) tick();
    check("stall_req_low", {31'b0, s_req}, 32'd0);
    check("stall_head_pc", s_pc, 32'd0);
    check("stall_fires", n_fire, 32'd4);
    i_ready = 1'b1;
    n0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("unstall_no_gap", {31'b0, s_valid}, 32'd1);
    end
    check("unstall_pops", n_pop - n0, 32'd8);

    // Redirect vectors: in-flight traffic, flush, first fetch/decode at the aligned target.
    for (int v = 0; v < 5; v++) begin
      lat_min = vecs[v].lat;
      lat_max = vecs[v].lat;
      repeat (5) tick();
      i_redirect = 1'b1;
      i_redirect_pc = vecs[v].target;
      tick();
      i_redirect = 1'b0;
      wait_req("redir_req", 20);
      check("redir_first_addr", s_addr, vecs[v].exp_addr);
      wait_req("redir_req2", 20);
      check("redir_second_addr", s_addr, vecs[v].exp_addr2);
      wait_valid("redir_valid", 20);
      check("redir_first_pc", s_pc, vecs[v].exp_addr);
      repeat (4) tick();
    end
    check("wrap_seen", {31'b0, saw_wrap}, 32'd1);

    // Back-to-back redirects: last target wins.
    lat_min = 2; lat_max = 2;
    repeat (4) tick();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h00000500;
    tick();
    i_redirect_pc = 32'h00000600;
    tick();
    i_redirect = 1'b0;
    wait_req("b2b_req", 20);
    check("b2b_addr", s_addr, 32'h00000600);
    wait_valid("b2b_valid", 20);
    check("b2b_pc", s_pc, 32'h00000600);

    // Randomised traffic with a mid-stream reset.
    lat_min = 1; lat_max = 5;
    spurious_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      i_ready       = ($urandom_range(0, 2) != 0);
      i_imem_ready  = ($urandom_range(0, 3) != 0);
      i_redirect    = ($urandom_range(0, 49) == 0);
      i_redirect_pc = $urandom();
      if (i == 1500) begin
        i_redirect = 1'b0;
        async_reset();
      end else begin
        tick();
      end
    end
    i_redirect = 1'b0;
    check("random_progress", {31'b0, (n_pop > 300)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
